// File: rtl/johnson_pkg.sv
// Shared Johnson-code helpers and lock FSM state type, used by both the
// Johnson counter and the receive-side decoder.
package johnson_pkg;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  // Helpers work on a zero-extended word; the live width is passed explicitly.
  localparam int JOHNSON_MAX_W = 32;

  typedef logic [JOHNSON_MAX_W-1:0] johnson_word_t;
  typedef logic [7:0]               johnson_idx_t;

  function automatic johnson_word_t johnson_next(input johnson_word_t code, input int width);
    johnson_word_t nxt;
    logic          msb;
    nxt = '0;
    msb = 1'b0;
    for (int i = 0; i < JOHNSON_MAX_W; i++) begin
      if (i == width - 1) msb = code[i];
    end
    for (int i = 1; i < JOHNSON_MAX_W; i++) begin
      if (i < width) nxt[i] = code[i-1];
    end
    nxt[0] = ~msb;
    return nxt;
  endfunction

  // Thermometer codes in either direction have at most one bit transition.
  function automatic logic johnson_is_legal(input johnson_word_t code, input int width);
    int edges;
    edges = 0;
    for (int i = 1; i < JOHNSON_MAX_W; i++) begin
      if ((i < width) && (code[i] != code[i-1])) edges++;
    end
    return (edges <= 1);
  endfunction

  function automatic johnson_idx_t johnson_to_idx(input johnson_word_t code, input int width);
    int   pop;
    logic msb;
    pop = 0;
    msb = 1'b0;
    for (int i = 0; i < JOHNSON_MAX_W; i++) begin
      if (i < width) pop += int'(code[i]);
      if (i == width - 1) msb = code[i];
    end
    if (!msb) return johnson_idx_t'(pop);
    return johnson_idx_t'(2 * width - pop);
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and binary index decode of one Johnson code.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code_i,
  output logic             legal_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    legal_o = johnson_is_legal(johnson_word_t'(code_i), WIDTH);
    idx_o   = IDX_W'(johnson_to_idx(johnson_word_t'(code_i), WIDTH));
  end

endmodule

// File: rtl/johnson_decoder.sv
// Receive-side Johnson decoder: binary index, illegal-code rejection,
// sequence lock tracking, step-error and wrap flags.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int IDX_W    = $clog2(2 * WIDTH),
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] code_i,
  input  logic             valid_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             idx_valid_o,
  output logic             illegal_o,
  output logic             seq_err_o,
  output logic             wrap_o,
  output logic             locked_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam int               RUN_W    = $clog2(LOCK_CNT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * WIDTH - 1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  lock_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [IDX_W-1:0] prev_idx_q, prev_idx_d;
  logic             prev_ok_q, prev_ok_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             illegal_q, illegal_d;
  logic             seq_err_q, seq_err_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             chk_legal;
  logic [IDX_W-1:0] chk_idx;
  logic [IDX_W-1:0] succ_idx;
  logic             correct;
  logic [RUN_W-1:0] run_inc;

  johnson_code_check #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_check (
    .code_i  (code_i),
    .legal_o (chk_legal),
    .idx_o   (chk_idx)
  );

  // 2*WIDTH need not be a power of two, so the successor wraps explicitly.
  assign succ_idx = (prev_idx_q == IDX_LAST) ? '0 : prev_idx_q + IDX_W'(1);
  assign correct  = chk_legal && prev_ok_q && (chk_idx == succ_idx);
  assign run_inc  = run_q + RUN_W'(1);

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    prev_idx_d  = prev_idx_q;
    prev_ok_d   = prev_ok_q;
    idx_d       = idx_q;
    idx_valid_d = 1'b0;
    illegal_d   = 1'b0;
    seq_err_d   = 1'b0;
    wrap_d      = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (valid_i) begin
      if (chk_legal) begin
        idx_d       = chk_idx;
        idx_valid_d = 1'b1;
        prev_idx_d  = chk_idx;
        prev_ok_d   = 1'b1;
      end else begin
        illegal_d = 1'b1;
        prev_ok_d = 1'b0;
      end

      unique case (state_q)
        ST_UNLOCKED: begin
          if (correct) begin
            if (run_inc == RUN_LOCK) begin
              state_d = ST_LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = '0;
          end
        end
        ST_LOCKED: begin
          if (correct) begin
            wrap_d = (prev_idx_q == IDX_LAST) && (chk_idx == '0);
          end else begin
            seq_err_d = 1'b1;
            state_d   = ST_UNLOCKED;
            run_d     = '0;
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_UNLOCKED;
      run_q       <= '0;
      prev_idx_q  <= '0;
      prev_ok_q   <= 1'b0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      prev_idx_q  <= prev_idx_d;
      prev_ok_q   <= prev_ok_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      wrap_q      <= wrap_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign idx_o       = idx_q;
  assign idx_valid_o = idx_valid_q;
  assign illegal_o   = illegal_q;
  assign seq_err_o   = seq_err_q;
  assign wrap_o      = wrap_q;
  assign locked_o    = (state_q == ST_LOCKED);
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (WIDTH=4, LOCK_CNT=3, ERR_W=2) with a
// table-driven reference model checked every cycle plus literal expectations.
module tb_johnson_decoder;

  localparam int W    = 4;
  localparam int N    = 2 * W;
  localparam int LOCK = 3;
  localparam int EW   = 2;
  localparam int IW   = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  code_i = '0;
  logic          valid_i = 1'b0;
  logic [IW-1:0] idx_o;
  logic          idx_valid_o;
  logic          illegal_o;
  logic          seq_err_o;
  logic          wrap_o;
  logic          locked_o;
  logic [EW-1:0] err_cnt_o;

  johnson_decoder #(
    .WIDTH    (W),
    .LOCK_CNT (LOCK),
    .ERR_W    (EW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .code_i      (code_i),
    .valid_i     (valid_i),
    .idx_o       (idx_o),
    .idx_valid_o (idx_valid_o),
    .illegal_o   (illegal_o),
    .seq_err_o   (seq_err_o),
    .wrap_o      (wrap_o),
    .locked_o    (locked_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Legal codes listed in sequence order; the position in the table is the index.
  logic [W-1:0] seq_tab [N];

  int m_idx      = 0;
  int m_prev_idx = 0;
  int m_run      = 0;
  int m_err      = 0;
  bit m_prev_ok  = 0;
  bit m_locked   = 0;
  bit m_iv       = 0;
  bit m_ill      = 0;
  bit m_serr     = 0;
  bit m_wrap     = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_prev_idx = 0; m_run = 0; m_err = 0;
    m_prev_ok = 0; m_locked = 0; m_iv = 0; m_ill = 0; m_serr = 0; m_wrap = 0;
  endtask

  task automatic model_step(input logic [W-1:0] c, input logic v);
    int pos;
    bit legal;
    bit correct;
    m_iv = 0; m_ill = 0; m_serr = 0; m_wrap = 0;
    if (!v) return;
    pos = -1;
    for (int k = 0; k < N; k++) if (seq_tab[k] == c) pos = k;
    legal   = (pos >= 0);
    correct = legal && m_prev_ok && (pos == (m_prev_idx + 1) % N);
    if (m_locked) begin
      if (correct) begin
        m_wrap = (m_prev_idx == N - 1) && (pos == 0);
      end else begin
        m_serr = 1;
        if (m_err < (1 << EW) - 1) m_err++;
        m_locked = 0;
        m_run = 0;
      end
    end else begin
      if (correct) m_run++;
      else m_run = 0;
      if (m_run == LOCK) begin
        m_locked = 1;
        m_run = 0;
      end
    end
    if (legal) begin
      m_idx = pos; m_iv = 1; m_prev_idx = pos; m_prev_ok = 1;
    end else begin
      m_ill = 1; m_prev_ok = 0;
    end
  endtask

  // Every clock out of reset: advance the model, then compare all outputs.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      model_step(code_i, valid_i);
      #1;
      check("m_idx",     int'(idx_o),       m_idx);
      check("m_idx_vld", int'(idx_valid_o), int'(m_iv));
      check("m_illegal", int'(illegal_o),   int'(m_ill));
      check("m_seq_err", int'(seq_err_o),   int'(m_serr));
      check("m_wrap",    int'(wrap_o),      int'(m_wrap));
      check("m_locked",  int'(locked_o),    int'(m_locked));
      check("m_err_cnt", int'(err_cnt_o),   m_err);
    end
  end

  task automatic step(input logic [W-1:0] c, input logic v);
    @(negedge clk);
    code_i  = c;
    valid_i = v;
    @(posedge clk);
    #2;
    $display("t=%0t code=%b v=%b -> idx=%0d iv=%b ill=%b serr=%b wrap=%b lock=%b err=%0d",
             $time, c, v, idx_o, idx_valid_o, illegal_o, seq_err_o, wrap_o, locked_o, err_cnt_o);
  endtask

  task automatic lit(input string tag, input int idx, input int ill, input int serr,
                     input int wrap, input int lock, input int err);
    check({tag, "_idx"},     int'(idx_o),     idx);
    check({tag, "_illegal"}, int'(illegal_o), ill);
    check({tag, "_seq_err"}, int'(seq_err_o), serr);
    check({tag, "_wrap"},    int'(wrap_o),    wrap);
    check({tag, "_locked"},  int'(locked_o),  lock);
    check({tag, "_err_cnt"}, int'(err_cnt_o), err);
  endtask

  initial begin
    logic [W-1:0] prev;
    seq_tab[0] = '0;
    for (int k = 1; k < N; k++) begin
      prev = seq_tab[k-1];
      seq_tab[k] = {prev[W-2:0], ~prev[W-1]};
    end

    repeat (3) @(posedge clk);
    #1;
    lit("reset", 0, 0, 0, 0, 0, 0);
    check("reset_idx_vld", int'(idx_valid_o), 0);
    @(negedge clk);
    reset = 1'b0;

    // Initial lock from reset
    step(4'b0000, 1'b1); lit("s0", 0, 0, 0, 0, 0, 0);
    check("s0_idx_vld", int'(idx_valid_o), 1);
    step(4'b0001, 1'b1); lit("s1", 1, 0, 0, 0, 0, 0);
    step(4'b0011, 1'b1); lit("s2", 2, 0, 0, 0, 0, 0);
    step(4'b0111, 1'b1); lit("s3_lock", 3, 0, 0, 0, 1, 0);

    // Walk the rest of the ring, wrap pulses only on 7 -> 0
    step(4'b1111, 1'b1); lit("s4", 4, 0, 0, 0, 1, 0);
    step(4'b1110, 1'b1); lit("s5", 5, 0, 0, 0, 1, 0);
    step(4'b1100, 1'b1); lit("s6", 6, 0, 0, 0, 1, 0);
    step(4'b1000, 1'b1); lit("s7", 7, 0, 0, 0, 1, 0);
    step(4'b0000, 1'b1); lit("wrap", 0, 0, 0, 1, 1, 0);

    // Illegal while locked
    step(4'b0101, 1'b1); lit("illegal", 0, 1, 1, 0, 0, 1);
    check("illegal_idx_vld", int'(idx_valid_o), 0);
    step(4'b0001, 1'b1); lit("rl1", 1, 0, 0, 0, 0, 1);
    step(4'b0011, 1'b1); lit("rl2", 2, 0, 0, 0, 0, 1);
    step(4'b0111, 1'b1); lit("rl3", 3, 0, 0, 0, 0, 1);
    step(4'b1111, 1'b1); lit("rl4_lock", 4, 0, 0, 0, 1, 1);

    // Advance to idx 2, then skip to idx 4
    step(4'b1110, 1'b1);
    step(4'b1100, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0011, 1'b1); lit("at2", 2, 0, 0, 0, 1, 1);
    step(4'b1111, 1'b1); lit("skip", 4, 0, 1, 0, 0, 2);
    step(4'b1110, 1'b1); lit("sk_rl1", 5, 0, 0, 0, 0, 2);
    step(4'b1100, 1'b1); lit("sk_rl2", 6, 0, 0, 0, 0, 2);
    step(4'b1000, 1'b1); lit("sk_rl3", 7, 0, 0, 0, 1, 2);

    // Valid gap between 0011 and 0111 while locked
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0011, 1'b1);
    for (int g = 0; g < 10; g++) begin
      step(4'b0101, 1'b0);
      lit("gap", 2, 0, 0, 0, 1, 2);
      check("gap_idx_vld", int'(idx_valid_o), 0);
    end
    step(4'b0111, 1'b1); lit("after_gap", 3, 0, 0, 0, 1, 2);

    // Further errors: counter saturates at 3
    step(4'b0111, 1'b1); lit("repeat", 3, 0, 1, 0, 0, 3);
    step(4'b1111, 1'b1);
    step(4'b1110, 1'b1);
    step(4'b1100, 1'b1); lit("rp_lock", 6, 0, 0, 0, 1, 3);
    step(4'b0000, 1'b1); lit("skip_sat", 0, 0, 1, 0, 0, 3);
    step(4'b0001, 1'b1);
    step(4'b0011, 1'b1);
    step(4'b0111, 1'b1); lit("sat_lock", 3, 0, 0, 0, 1, 3);
    step(4'b1010, 1'b1); lit("illegal_sat", 3, 1, 1, 0, 0, 3);

    // Relock, then asynchronous reset mid-cycle with valid high
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0011, 1'b1);
    step(4'b0111, 1'b1); lit("pre_rst", 3, 0, 0, 0, 1, 3);
    @(negedge clk);
    code_i  = 4'b1111;
    valid_i = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    lit("async_rst", 0, 0, 0, 0, 0, 0);
    check("async_rst_idx_vld", int'(idx_valid_o), 0);
    repeat (2) @(posedge clk);
    #1;
    lit("held_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    valid_i = 1'b0;
    reset   = 1'b0;
    step(4'b1111, 1'b1); lit("pr0", 4, 0, 0, 0, 0, 0);
    step(4'b1110, 1'b1); lit("pr1", 5, 0, 0, 0, 0, 0);
    step(4'b1100, 1'b1); lit("pr2", 6, 0, 0, 0, 0, 0);
    step(4'b1000, 1'b1); lit("pr3_lock", 7, 0, 0, 0, 1, 0);
    step(4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
